// File: rtl/wb_uart_tx_slave.sv
// Wishbone B4 pipelined slave: TX FIFO feeding an 8N1 serialiser.
// Registers: 0 TXDATA (W), 1 STATUS (R), 2 BAUDDIV (RW), 3 unmapped (err).
module wb_uart_tx_slave #(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter logic [15:0] BAUDDIV_RESET = 16'd3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit;
    logic [15:0] r_baud;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_off;
    logic        w_req;
    logic        w_txw;
    logic        w_accept;
    logic        w_baud_wr;
    logic [31:0] w_rdata;
    logic        w_cnt_zero;
    logic        w_tx;
    logic        w_busy;
    logic        w_unused;

    assign w_unused = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_off      = wb_adr_i[3:2];
    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_txw      = wb_we_i & (w_off == 2'd0) & wb_sel_i[0];
    assign wb_stall_o = w_req & w_txw & w_full;
    assign w_accept   = w_req & ~wb_stall_o;
    assign w_push     = w_accept & w_txw;
    assign w_baud_wr  = w_accept & wb_we_i & (w_off == 2'd2);
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_cnt_zero = (r_cnt == 16'd0);

    // Read data as seen before this cycle's push/pop
    always_comb begin
        w_rdata = '0;
        if (!wb_we_i) begin
            case (w_off)
                2'd1:    w_rdata[2:0]  = {w_busy, w_empty, w_full};
                2'd2:    w_rdata[15:0] = r_baud;
                default: w_rdata = '0;
            endcase
        end
    end

    // Registered response: one ack or err per accepted request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_accept & (w_off != 2'd3);
            r_err <= w_accept & (w_off == 2'd3);
            r_dat <= w_accept ? w_rdata : '0;
        end
    end

    assign wb_ack_o = r_ack & wb_cyc_i;
    assign wb_err_o = r_err & wb_cyc_i;
    assign wb_dat_o = wb_ack_o ? r_dat : '0;

    // Baud divisor with byte-lane writes
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_baud <= BAUDDIV_RESET;
        end else if (w_baud_wr) begin
            if (wb_sel_i[0]) r_baud[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) r_baud[15:8] <= wb_dat_i[15:8];
        end
    end

    // FIFO pointers, wrapping modulo 2*FIFO_DEPTH
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge wb_clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
    end

    // TX state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // TX next-state: each phase lasts until the baud counter reaches zero
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_START;
            S_START: if (w_cnt_zero) w_state_nxt = S_DATA;
            S_DATA:  if (w_cnt_zero && (r_bit == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_cnt_zero) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // TX datapath: baud counter reloads from BAUDDIV at every bit boundary
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr[AW-1:0]];
                        r_cnt   <= r_baud;
                    end
                end
                S_START: begin
                    if (w_cnt_zero) begin
                        r_cnt <= r_baud;
                        r_bit <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= r_baud;
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 16'd1;
                end
            endcase
        end
    end

    // TX outputs decoded from state
    always_comb begin
        w_tx   = 1'b1;
        w_busy = (r_state != S_IDLE);
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_shift[0];
            default: w_tx = 1'b1;
        endcase
    end

    assign tx_o  = w_tx;
    assign irq_o = w_empty & ~w_busy;

endmodule

// File: tb/tb_wb_uart_tx_slave.sv
// Self-checking bench for wb_uart_tx_slave: queue/frame-timing reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_uart_tx_slave;

    localparam int DEPTH = 16;
    localparam int TLOG  = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        stall;
    logic        ack;
    logic        err;
    logic        tx;
    logic        irq;
    logic [31:0] rdat;

    always #5 clk = ~clk;

    wb_uart_tx_slave #(
        .FIFO_DEPTH    (DEPTH),
        .BAUDDIV_RESET (16'd3)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (wdat),
        .wb_sel_i   (sel),
        .wb_stall_o (stall),
        .wb_ack_o   (ack),
        .wb_dat_o   (rdat),
        .wb_err_o   (err),
        .tx_o       (tx),
        .irq_o      (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO as a queue, the frame in flight as start cycle + bit period
    logic [7:0]  m_q[$];
    bit          m_busy = 1'b0;
    int          m_fstart = 0;
    int          m_per = 1;
    logic [7:0]  m_byte = '0;
    logic [15:0] m_baud = 16'd3;
    bit          m_ack = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_dat = '0;
    bit          m_stall_now = 1'b0;
    int          cyc_n = 0;
    bit          tx_log [TLOG];
    bit          irq_log [TLOG];
    logic [7:0]  dec_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_n, act, exp);
        end
    endtask

    function automatic bit exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = (cyc_n - m_fstart) / m_per;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic bit exp_stall();
        return cyc && stb && we && (adr[3:2] == 2'd0) && sel[0] && (m_q.size() == DEPTH);
    endfunction

    task automatic compare_all();
        bit    e_ack;
        if (m_busy && (cyc_n >= m_fstart + 10 * m_per)) m_busy = 1'b0;
        m_stall_now = exp_stall();
        e_ack = m_ack && cyc;
        check("stall", stall, m_stall_now);
        check("ack",   ack,   e_ack);
        check("err",   err,   m_err && cyc);
        check("dat",   rdat,  e_ack ? m_dat : 32'h0);
        check("tx",    tx,    exp_tx());
        check("irq",   irq,   (m_q.size() == 0) && !m_busy);
        tx_log[cyc_n]  = tx;
        irq_log[cyc_n] = irq;
    endtask

    task automatic model_edge();
        bit         full;
        bit         empty;
        bit         busy;
        logic [1:0] off;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        busy  = m_busy;
        if (!busy && !empty) begin
            m_byte   = m_q.pop_front();
            m_busy   = 1'b1;
            m_fstart = cyc_n + 1;
            m_per    = int'(m_baud) + 1;
        end
        m_ack = 1'b0;
        m_err = 1'b0;
        m_dat = '0;
        if (cyc && stb && !m_stall_now) begin
            off = adr[3:2];
            if (off == 2'd3) begin
                m_err = 1'b1;
            end else begin
                m_ack = 1'b1;
                if (!we) begin
                    if (off == 2'd1) m_dat = {29'h0, busy, empty, full};
                    else if (off == 2'd2) m_dat = {16'h0, m_baud};
                end else if (off == 2'd0) begin
                    if (sel[0]) m_q.push_back(wdat[7:0]);
                end else if (off == 2'd2) begin
                    if (sel[0]) m_baud[7:0]  = wdat[7:0];
                    if (sel[1]) m_baud[15:8] = wdat[15:8];
                end
            end
        end
        cyc_n++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic req(input bit w, input logic [1:0] off, input logic [31:0] d,
                       input logic [3:0] s, output int stalls);
        logic [31:0] a;
        a      = $urandom;
        a[3:2] = off;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        stalls = 0;
        for (int g = 0; g < 3000; g++) begin
            tick();
            if (!m_stall_now) return;
            stalls++;
        end
        n_checks++;
        n_fail++;
        $display("FAIL req_timeout: request still stalled after %0d cycles, required acceptance", stalls);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #1;
        check({tag, "_tx"},    tx,    32'h1);
        check({tag, "_irq"},   irq,   32'h1);
        check({tag, "_ack"},   ack,   32'h0);
        check({tag, "_err"},   err,   32'h0);
        check({tag, "_stall"}, stall, 32'h0);
        check({tag, "_dat"},   rdat,  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_busy = 1'b0; m_baud = 16'd3;
        m_ack = 1'b0; m_err = 1'b0; m_dat = '0; m_stall_now = 1'b0;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Independent 8N1 receiver over the logged line, sampling mid-bit
    task automatic decode(input int from, input int upto, input int p);
        int i;
        dec_q.delete();
        i = from + 1;
        while (i + 10 * p <= upto) begin
            if (!tx_log[i] && tx_log[i-1]) begin
                logic [7:0] b;
                for (int k = 0; k < 8; k++) b[k] = tx_log[i + (k + 1) * p + p / 2];
                check("dec_stop", tx_log[i + 9 * p + p / 2], 32'h1);
                dec_q.push_back(b);
                i += 10 * p;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         st;
        int         c;
        int         sum;
        logic [7:0] sent[$];
        bit         exp10 [10];
        logic [3:0] win;

        exp10 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        #2;
        do_reset("rst0");

        // Status after reset
        req(1'b0, 2'd1, 32'h0, 4'hF, st);
        check("t1_ack", ack, 32'h1);
        check("t1_dat", rdat, 32'h2);
        check("t1_irq", irq, 32'h1);
        check("t1_tx",  tx,  32'h1);
        idle(2);

        // 0x55 at BAUDDIV=3
        req(1'b1, 2'd2, 32'h3, 4'h3, st);
        idle(1);
        req(1'b1, 2'd0, 32'h55, 4'h1, st);
        c = cyc_n - 1;
        idle(45);
        check("t2_pre", tx_log[c + 1], 32'h1);
        for (int k = 0; k < 10; k++) begin
            win = {tx_log[c + 2 + 4 * k], tx_log[c + 3 + 4 * k],
                   tx_log[c + 4 + 4 * k], tx_log[c + 5 + 4 * k]};
            check("t2_bit", win, exp10[k] ? 32'hF : 32'h0);
        end
        check("t2_idle_after", tx_log[c + 42], 32'h1);
        check("t2_irq_stop",   irq_log[c + 41], 32'h0);
        check("t2_irq_after",  irq_log[c + 42], 32'h1);

        // Unmapped offset then BAUDDIV read, back to back
        req(1'b0, 2'd3, 32'h0, 4'hF, st);
        check("t4_err", err, 32'h1);
        check("t4_ack0", ack, 32'h0);
        req(1'b0, 2'd2, 32'h0, 4'hF, st);
        check("t4_ack", ack, 32'h1);
        check("t4_err0", err, 32'h0);
        check("t4_dat", rdat, 32'h3);
        idle(2);

        // TXDATA write without lane 0
        req(1'b1, 2'd0, 32'hAB, 4'hE, st);
        check("t5_ack", ack, 32'h1);
        idle(5);
        req(1'b1 ^ 1'b1, 2'd1, 32'h0, 4'hF, st);
        check("t5_status", rdat, 32'h2);
        idle(2);

        // 18 back-to-back pushes at BAUDDIV=1 (10-clock... 20-clock frames)
        req(1'b1, 2'd2, 32'h1, 4'h3, st);
        idle(2);
        sum = 0;
        c = cyc_n;
        sent.delete();
        for (int i = 0; i < 18; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sent.push_back(b);
            req(1'b1, 2'd0, {24'($urandom), b}, 4'h1, st);
            if (i < 17) sum += st;
        end
        check("t3_nostall17", sum, 32'h0);
        check("t3_stall18", st, 32'd6);
        idle(420);
        decode(c, cyc_n, 2);
        check("t3_nframes", dec_q.size(), 32'd18);
        for (int i = 0; i < 18 && i < dec_q.size(); i++) check("t3_byte", dec_q[i], sent[i]);

        // Reset in the middle of data bit 4
        req(1'b1, 2'd2, 32'h3, 4'h3, st);
        idle(1);
        req(1'b1, 2'd0, 32'h0F, 4'h1, st);
        idle(22);
        check("t6_midframe", tx, 32'h0);
        do_reset("rst6");
        req(1'b0, 2'd1, 32'h0, 4'hF, st);
        check("t6_status", rdat, 32'h2);
        idle(2);
        c = cyc_n;
        req(1'b1, 2'd0, 32'hC3, 4'h1, st);
        idle(45);
        decode(c, cyc_n, 4);
        check("t6_nframes", dec_q.size(), 32'd1);
        if (dec_q.size() > 0) check("t6_byte", dec_q[0], 32'hC3);

        // Randomised traffic; stalled requests are held until accepted
        for (int n = 0; n < 4000; n++) begin
            if (!(cyc && stb && m_stall_now)) begin
                int         r;
                logic [1:0] off;
                logic [31:0] a;
                cyc = ($urandom % 10) != 0;
                stb = cyc && (($urandom % 10) < 6);
                we  = $urandom % 2;
                r   = $urandom % 8;
                off = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
                if (we && off == 2'd2 && !(m_q.size() == 0 && !m_busy)) we = 1'b0;
                a      = $urandom;
                a[3:2] = off;
                adr    = a;
                wdat   = $urandom;
                if (off == 2'd2) wdat[15:0] = 16'($urandom % 4);
                sel    = 4'($urandom);
            end
            tick();
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
